// File: rtl/debug_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | debug_pkg : command codes, FSM encodings and dump geometry         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package debug_pkg;

   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_CONT = 8'h43;
   localparam logic [7:0] CMD_STEP = 8'h53;

   localparam int IF_ID_W  = 64;
   localparam int ID_EX_W  = 139;
   localparam int EX_MEM_W = 76;
   localparam int MEM_WB_W = 71;

   localparam int IF_ID_BYTES  = 8;
   localparam int ID_EX_BYTES  = 18;
   localparam int EX_MEM_BYTES = 10;
   localparam int MEM_WB_BYTES = 9;
   localparam int LATCH_BYTES  = IF_ID_BYTES + ID_EX_BYTES + EX_MEM_BYTES + MEM_WB_BYTES;
   localparam int SNAP_W       = LATCH_BYTES * 8;
   localparam int NUM_REGS     = 32;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_LOAD_COUNT = 3'd1,
      ST_LOAD_BYTES = 3'd2,
      ST_LOAD_WRITE = 3'd3,
      ST_RUN        = 3'd4,
      ST_STEP       = 3'd5,
      ST_DUMP       = 3'd6,
      ST_TX_WAIT    = 3'd7
   } state_e;

   typedef enum logic [1:0] {
      SEC_LATCH = 2'd0,
      SEC_REG   = 2'd1,
      SEC_MEM   = 2'd2
   } section_e;

   typedef enum logic [1:0] {
      SER_IDLE = 2'd0,
      SER_SEND = 2'd1,
      SER_WAIT = 2'd2
   } ser_state_e;

endpackage
`default_nettype wire

// File: rtl/dump_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dump_serializer : sends 1..4 bytes of a word MSB first over tx     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dump_serializer
   import debug_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [31:0] i_word,
   input  logic [2:0]  i_nbytes,
   input  logic        i_tx_done,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_start,
   output logic        o_done
);

   ser_state_e  state_q, state_d;
   logic [31:0] shreg_q, shreg_d;
   logic [2:0]  left_q, left_d;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= SER_IDLE;
         shreg_q <= '0;
         left_q  <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         left_q  <= left_d;
      end
   end

   // The byte on the wire only moves after the receiver acknowledges it.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      left_d  = left_q;
      o_done  = 1'b0;
      case (state_q)
         SER_IDLE: begin
            if (i_start) begin
               shreg_d = i_word;
               left_d  = i_nbytes;
               state_d = SER_SEND;
            end
         end
         SER_SEND: state_d = SER_WAIT;
         SER_WAIT: begin
            if (i_tx_done) begin
               shreg_d = {shreg_q[23:0], 8'h00};
               left_d  = left_q - 3'd1;
               if (left_q == 3'd1) begin
                  o_done  = 1'b1;
                  state_d = SER_IDLE;
               end else begin
                  state_d = SER_SEND;
               end
            end
         end
         default: state_d = SER_IDLE;
      endcase
   end

   assign o_tx_start = (state_q == SER_SEND);
   assign o_tx_data  = shreg_q[31:24];

endmodule
`default_nettype wire

// File: rtl/debug_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | debug_unit : UART-driven program loader, run/step control and dump |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module debug_unit
   import debug_pkg::*;
#(
   parameter int IMEM_WORDS     = 256,
   parameter int DUMP_MEM_WORDS = 32
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [7:0]          i_rx_data,
   input  logic                i_rx_done,
   input  logic                i_tx_done,
   output logic [7:0]          o_tx_data,
   output logic                o_tx_start,
   output logic                o_halt,
   output logic                o_write_instruction_flag,
   output logic [31:0]         o_instruction_to_write,
   output logic [31:0]         o_address_to_write_inst,
   input  logic [IF_ID_W-1:0]  i_IF_ID_latch,
   input  logic [ID_EX_W-1:0]  i_ID_EX_latch,
   input  logic [EX_MEM_W-1:0] i_EX_MEM_latch,
   input  logic [MEM_WB_W-1:0] i_MEM_WB_latch,
   output logic [4:0]          o_reg_read,
   input  logic [31:0]         i_reg_content,
   output logic [31:0]         o_address_to_read,
   input  logic [31:0]         i_mem_addr_content,
   input  logic                i_program_end
);

   state_e            state_q, state_d;
   section_e          sec_q, sec_d;
   logic [31:0]       count_q, count_d;
   logic [31:0]       word_idx_q, word_idx_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [23:0]       word_q, word_d;
   logic [31:0]       instr_q, instr_d;
   logic [31:0]       waddr_q, waddr_d;
   logic [SNAP_W-1:0] snap_q, snap_d;
   logic [5:0]        lat_left_q, lat_left_d;
   logic [31:0]       idx_q, idx_d;
   logic [1:0]        phase_q, phase_d;
   logic [4:0]        reg_read_q, reg_read_d;
   logic [31:0]       rd_addr_q, rd_addr_d;

   logic              w_enter_dump;
   logic              w_ser_start;
   logic [31:0]       w_ser_word;
   logic [2:0]        w_ser_nbytes;
   logic              w_ser_done;
   logic [31:0]       w_rx_count;
   logic [SNAP_W-1:0] w_snapshot;

   assign w_rx_count = {24'd0, i_rx_data};
   assign w_snapshot = {i_IF_ID_latch,
                        {(ID_EX_BYTES*8 - ID_EX_W){1'b0}},   i_ID_EX_latch,
                        {(EX_MEM_BYTES*8 - EX_MEM_W){1'b0}}, i_EX_MEM_latch,
                        {(MEM_WB_BYTES*8 - MEM_WB_W){1'b0}}, i_MEM_WB_latch};

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= ST_IDLE;
         sec_q      <= SEC_LATCH;
         count_q    <= '0;
         word_idx_q <= '0;
         byte_idx_q <= '0;
         word_q     <= '0;
         instr_q    <= '0;
         waddr_q    <= '0;
         snap_q     <= '0;
         lat_left_q <= '0;
         idx_q      <= '0;
         phase_q    <= '0;
         reg_read_q <= '0;
         rd_addr_q  <= '0;
      end else begin
         state_q    <= state_d;
         sec_q      <= sec_d;
         count_q    <= count_d;
         word_idx_q <= word_idx_d;
         byte_idx_q <= byte_idx_d;
         word_q     <= word_d;
         instr_q    <= instr_d;
         waddr_q    <= waddr_d;
         snap_q     <= snap_d;
         lat_left_q <= lat_left_d;
         idx_q      <= idx_d;
         phase_q    <= phase_d;
         reg_read_q <= reg_read_d;
         rd_addr_q  <= rd_addr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      sec_d        = sec_q;
      count_d      = count_q;
      word_idx_d   = word_idx_q;
      byte_idx_d   = byte_idx_q;
      word_d       = word_q;
      instr_d      = instr_q;
      waddr_d      = waddr_q;
      snap_d       = snap_q;
      lat_left_d   = lat_left_q;
      idx_d        = idx_q;
      phase_d      = phase_q;
      reg_read_d   = reg_read_q;
      rd_addr_d    = rd_addr_q;
      w_enter_dump = 1'b0;
      w_ser_start  = 1'b0;
      w_ser_word   = '0;
      w_ser_nbytes = '0;
      case (state_q)
         ST_IDLE: begin
            if (i_rx_done) begin
               if (i_rx_data == CMD_LOAD) begin
                  state_d = ST_LOAD_COUNT;
               end else if (i_rx_data == CMD_CONT) begin
                  if (i_program_end) w_enter_dump = 1'b1;
                  else               state_d = ST_RUN;
               end else if (i_rx_data == CMD_STEP) begin
                  if (i_program_end) w_enter_dump = 1'b1;
                  else               state_d = ST_STEP;
               end
            end
         end
         ST_LOAD_COUNT: begin
            if (i_rx_done) begin
               if (i_rx_data == 8'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  count_d    = (w_rx_count > 32'(IMEM_WORDS)) ? 32'(IMEM_WORDS) : w_rx_count;
                  word_idx_d = '0;
                  byte_idx_d = '0;
                  state_d    = ST_LOAD_BYTES;
               end
            end
         end
         ST_LOAD_BYTES: begin
            if (i_rx_done) begin
               word_d     = {word_q[15:0], i_rx_data};
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  instr_d = {word_q, i_rx_data};
                  waddr_d = {word_idx_q[29:0], 2'b00};
                  state_d = ST_LOAD_WRITE;
               end
            end
         end
         ST_LOAD_WRITE: begin
            word_idx_d = word_idx_q + 32'd1;
            state_d    = (word_idx_q + 32'd1 >= count_q) ? ST_IDLE : ST_LOAD_BYTES;
         end
         ST_RUN:  if (i_program_end) w_enter_dump = 1'b1;
         ST_STEP: w_enter_dump = 1'b1;
         ST_DUMP: begin
            if (sec_q == SEC_LATCH) begin
               w_ser_start  = 1'b1;
               w_ser_word   = snap_q[SNAP_W-1 -: 32];
               w_ser_nbytes = (lat_left_q >= 6'd4) ? 3'd4 : lat_left_q[2:0];
               snap_d       = snap_q << 32;
               lat_left_d   = lat_left_q - {3'd0, w_ser_nbytes};
               state_d      = ST_TX_WAIT;
            end else if (phase_q == 2'd0) begin
               if (sec_q == SEC_REG) reg_read_d = idx_q[4:0];
               else                  rd_addr_d  = {idx_q[29:0], 2'b00};
               phase_d = 2'd1;
            end else if (phase_q == 2'd1) begin
               phase_d = 2'd2;
            end else begin
               // Two edges after the address moved, the read data is settled.
               w_ser_start  = 1'b1;
               w_ser_word   = (sec_q == SEC_REG) ? i_reg_content : i_mem_addr_content;
               w_ser_nbytes = 3'd4;
               phase_d      = 2'd0;
               state_d      = ST_TX_WAIT;
            end
         end
         ST_TX_WAIT: begin
            if (w_ser_done) begin
               state_d = ST_DUMP;
               if (sec_q == SEC_LATCH) begin
                  if (lat_left_q == 6'd0) begin
                     sec_d = SEC_REG;
                     idx_d = '0;
                  end
               end else if (sec_q == SEC_REG) begin
                  if (idx_q == 32'(NUM_REGS - 1)) begin
                     sec_d = SEC_MEM;
                     idx_d = '0;
                  end else begin
                     idx_d = idx_q + 32'd1;
                  end
               end else begin
                  if (idx_q == 32'(DUMP_MEM_WORDS - 1)) state_d = ST_IDLE;
                  else                                 idx_d   = idx_q + 32'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (w_enter_dump) begin
         state_d    = ST_DUMP;
         snap_d     = w_snapshot;
         lat_left_d = 6'(LATCH_BYTES);
         sec_d      = SEC_LATCH;
         idx_d      = '0;
         phase_d    = '0;
      end
   end

   dump_serializer u_ser (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_start    (w_ser_start),
      .i_word     (w_ser_word),
      .i_nbytes   (w_ser_nbytes),
      .i_tx_done  (i_tx_done),
      .o_tx_data  (o_tx_data),
      .o_tx_start (o_tx_start),
      .o_done     (w_ser_done)
   );

   assign o_halt                   = !((state_q == ST_RUN) || (state_q == ST_STEP));
   assign o_write_instruction_flag = (state_q == ST_LOAD_WRITE);
   assign o_instruction_to_write   = instr_q;
   assign o_address_to_write_inst  = waddr_q;
   assign o_reg_read               = reg_read_q;
   assign o_address_to_read        = rd_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_debug_unit : directed self-checking bench for debug_unit        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_debug_unit;

   logic         i_clk = 1'b0;
   logic         i_reset;
   logic [7:0]   i_rx_data;
   logic         i_rx_done;
   logic         i_tx_done;
   logic [7:0]   o_tx_data;
   logic         o_tx_start;
   logic         o_halt;
   logic         o_write_instruction_flag;
   logic [31:0]  o_instruction_to_write;
   logic [31:0]  o_address_to_write_inst;
   logic [63:0]  i_IF_ID_latch;
   logic [138:0] i_ID_EX_latch;
   logic [75:0]  i_EX_MEM_latch;
   logic [70:0]  i_MEM_WB_latch;
   logic [4:0]   o_reg_read;
   logic [31:0]  i_reg_content;
   logic [31:0]  o_address_to_read;
   logic [31:0]  i_mem_addr_content;
   logic         i_program_end;

   always #5 i_clk = ~i_clk;

   debug_unit #(.IMEM_WORDS(4), .DUMP_MEM_WORDS(32)) dut (
      .i_clk                    (i_clk),
      .i_reset                  (i_reset),
      .i_rx_data                (i_rx_data),
      .i_rx_done                (i_rx_done),
      .i_tx_done                (i_tx_done),
      .o_tx_data                (o_tx_data),
      .o_tx_start               (o_tx_start),
      .o_halt                   (o_halt),
      .o_write_instruction_flag (o_write_instruction_flag),
      .o_instruction_to_write   (o_instruction_to_write),
      .o_address_to_write_inst  (o_address_to_write_inst),
      .i_IF_ID_latch            (i_IF_ID_latch),
      .i_ID_EX_latch            (i_ID_EX_latch),
      .i_EX_MEM_latch           (i_EX_MEM_latch),
      .i_MEM_WB_latch           (i_MEM_WB_latch),
      .o_reg_read               (o_reg_read),
      .i_reg_content            (i_reg_content),
      .o_address_to_read        (o_address_to_read),
      .i_mem_addr_content       (i_mem_addr_content),
      .i_program_end            (i_program_end)
   );

   function automatic logic [31:0] regval(input logic [4:0] r);
      return {3'b000, r, 8'hC3, 3'b000, r, 8'h5A};
   endfunction

   function automatic logic [31:0] memval(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // Register file and data memory with one cycle of read latency.
   always @(posedge i_clk) begin
      i_reg_content      <= regval(o_reg_read);
      i_mem_addr_content <= memval(o_address_to_read);
   end

   int         halt_low_cnt = 0;
   int         overlap_err  = 0;
   int         stable_err   = 0;
   int         tx_delay     = 2;
   int         tx_cnt       = 0;
   logic       tx_pending   = 1'b0;
   logic [7:0] tx_held      = 8'h00;
   logic [7:0]  dump_q [$];
   logic [31:0] wr_addr_q [$];
   logic [31:0] wr_data_q [$];

   always @(negedge i_clk) begin
      i_tx_done = 1'b0;
      if (!o_halt) halt_low_cnt++;
      if (o_write_instruction_flag) begin
         wr_addr_q.push_back(o_address_to_write_inst);
         wr_data_q.push_back(o_instruction_to_write);
      end
      if (o_tx_start && tx_pending) overlap_err++;
      if (tx_pending) begin
         if (o_tx_data !== tx_held) stable_err++;
         if (tx_cnt == 0) begin
            i_tx_done  = 1'b1;
            tx_pending = 1'b0;
         end else begin
            tx_cnt--;
         end
      end else if (o_tx_start) begin
         tx_pending = 1'b1;
         tx_cnt     = tx_delay;
         tx_held    = o_tx_data;
         dump_q.push_back(o_tx_data);
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [7:0] exp_bytes [301];

   task automatic build_exp();
      logic [359:0] s;
      logic [31:0]  w;
      s = {i_IF_ID_latch, 5'b0, i_ID_EX_latch, 4'b0, i_EX_MEM_latch, 1'b0, i_MEM_WB_latch};
      for (int i = 0; i < 45; i++) exp_bytes[i] = s[359-8*i -: 8];
      for (int r = 0; r < 32; r++) begin
         w = regval(5'(r));
         for (int b = 0; b < 4; b++) exp_bytes[45+4*r+b] = w[31-8*b -: 8];
      end
      for (int m = 0; m < 32; m++) begin
         w = memval(32'(4*m));
         for (int b = 0; b < 4; b++) exp_bytes[173+4*m+b] = w[31-8*b -: 8];
      end
   endtask

   function automatic int dump_errs(input int base);
      int e = 0;
      for (int i = 0; i < 301; i++)
         if (base + i >= dump_q.size() || dump_q[base+i] !== exp_bytes[i]) e++;
      return e;
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge i_clk);
      i_rx_data = b;
      i_rx_done = 1'b1;
      @(negedge i_clk);
      i_rx_done = 1'b0;
      repeat (gap) @(negedge i_clk);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8], 3);
   endtask

   task automatic wait_dump(input string tag, input int base, input int budget);
      int c = 0;
      while (dump_q.size() < base + 301 && c < budget) begin
         @(negedge i_clk);
         c++;
      end
      repeat (30) @(negedge i_clk);
      chk(tag, 64'(dump_q.size() - base), 64'd301);
   endtask

   task automatic pulse_reset();
      @(negedge i_clk);
      i_reset = 1'b1;
      @(negedge i_clk);
      i_reset = 1'b0;
   endtask

   int wb, db, hb, ob, sb;

   initial begin
      i_reset        = 1'b1;
      i_rx_data      = 8'h00;
      i_rx_done      = 1'b0;
      i_program_end  = 1'b0;
      i_IF_ID_latch  = 64'h1122_3344_5566_7788;
      i_ID_EX_latch  = {11'h5A5, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0};
      i_EX_MEM_latch = {12'hABC, 64'h0123_4567_89AB_CDEF};
      i_MEM_WB_latch = {7'h55, 64'hFEDC_BA98_7654_3210};
      repeat (3) @(negedge i_clk);
      i_reset = 1'b0;
      @(negedge i_clk);

      chk("rst_halt",   64'(o_halt), 64'd1);
      chk("rst_wflag",  64'(o_write_instruction_flag), 64'd0);
      chk("rst_txs",    64'(o_tx_start), 64'd0);
      chk("rst_txd",    64'(o_tx_data), 64'd0);
      chk("rst_instr",  64'(o_instruction_to_write), 64'd0);
      chk("rst_waddr",  64'(o_address_to_write_inst), 64'd0);
      chk("rst_regrd",  64'(o_reg_read), 64'd0);
      chk("rst_rdaddr", 64'(o_address_to_read), 64'd0);

      // Two-word load
      wb = wr_addr_q.size(); hb = halt_low_cnt;
      send_byte(8'h4C, 3); send_byte(8'h02, 3);
      send_word(32'h2001_0005); send_word(32'h0000_0000);
      repeat (5) @(negedge i_clk);
      chk("load_nwr", 64'(wr_addr_q.size() - wb), 64'd2);
      if (wr_addr_q.size() >= wb + 2) begin
         chk("load_a0", 64'(wr_addr_q[wb]),   64'h0);
         chk("load_d0", 64'(wr_data_q[wb]),   64'h2001_0005);
         chk("load_a1", 64'(wr_addr_q[wb+1]), 64'h4);
         chk("load_d1", 64'(wr_data_q[wb+1]), 64'h0);
      end
      chk("load_halt", 64'(halt_low_cnt - hb), 64'd0);

      // Count above IMEM_WORDS=4 is clamped to 4 writes
      wb = wr_addr_q.size();
      send_byte(8'h4C, 3); send_byte(8'h06, 3);
      for (int k = 0; k < 4; k++) send_word(32'hC0DE_0000 + 32'(k));
      repeat (5) @(negedge i_clk);
      chk("clamp_nwr", 64'(wr_addr_q.size() - wb), 64'd4);
      if (wr_addr_q.size() >= wb + 4) begin
         chk("clamp_a3", 64'(wr_addr_q[wb+3]), 64'hC);
         chk("clamp_d3", 64'(wr_data_q[wb+3]), 64'hC0DE_0003);
      end

      // Unknown command then zero-length load
      wb = wr_addr_q.size(); db = dump_q.size(); hb = halt_low_cnt;
      send_byte(8'h7A, 3); send_byte(8'h4C, 3); send_byte(8'h00, 3);
      repeat (10) @(negedge i_clk);
      chk("unk_nwr",  64'(wr_addr_q.size() - wb), 64'd0);
      chk("unk_ntx",  64'(dump_q.size() - db), 64'd0);
      chk("unk_halt", 64'(halt_low_cnt - hb), 64'd0);

      // Reset after third byte of a word
      wb = wr_addr_q.size();
      send_byte(8'h4C, 3); send_byte(8'h01, 3);
      send_byte(8'hAA, 3); send_byte(8'hBB, 3); send_byte(8'hCC, 3);
      pulse_reset();
      repeat (3) @(negedge i_clk);
      chk("rstld_nwr",  64'(wr_addr_q.size() - wb), 64'd0);
      chk("rstld_halt", 64'(o_halt), 64'd1);
      chk("rstld_addr", 64'(o_address_to_write_inst), 64'd0);
      send_byte(8'h4C, 3); send_byte(8'h01, 3); send_word(32'h1122_3344);
      repeat (5) @(negedge i_clk);
      chk("rstld_nwr2", 64'(wr_addr_q.size() - wb), 64'd1);
      if (wr_addr_q.size() >= wb + 1) begin
         chk("rstld_a", 64'(wr_addr_q[wb]), 64'h0);
         chk("rstld_d", 64'(wr_data_q[wb]), 64'h1122_3344);
      end

      // Step: snapshot taken at dump entry, latches change right after
      build_exp();
      db = dump_q.size(); hb = halt_low_cnt;
      send_byte(8'h53, 0);
      @(negedge i_clk);
      i_IF_ID_latch  = ~i_IF_ID_latch;
      i_ID_EX_latch  = ~i_ID_EX_latch;
      i_EX_MEM_latch = ~i_EX_MEM_latch;
      i_MEM_WB_latch = ~i_MEM_WB_latch;
      wait_dump("step_nbytes", db, 5000);
      chk("step_halt_low", 64'(halt_low_cnt - hb), 64'd1);
      for (int i = 0; i < 301; i++)
         if (db + i < dump_q.size())
            chk($sformatf("step_byte%0d", i), 64'(dump_q[db+i]), 64'(exp_bytes[i]));

      // Run: program_end raised 20 cycles after 'C'
      build_exp();
      db = dump_q.size(); hb = halt_low_cnt;
      @(negedge i_clk);
      i_rx_data = 8'h43;
      i_rx_done = 1'b1;
      @(negedge i_clk);
      i_rx_done = 1'b0;
      repeat (19) @(negedge i_clk);
      chk("run_halt_before", 64'(o_halt), 64'd0);
      i_program_end = 1'b1;
      @(negedge i_clk);
      i_program_end = 1'b0;
      chk("run_halt_after", 64'(o_halt), 64'd1);
      wait_dump("run_nbytes", db, 5000);
      chk("run_halt_low", 64'(halt_low_cnt - hb), 64'd20);
      chk("run_errs", 64'(dump_errs(db)), 64'd0);

      // Program already ended: 'C' dumps without releasing halt
      db = dump_q.size(); hb = halt_low_cnt;
      @(negedge i_clk);
      i_program_end = 1'b1;
      send_byte(8'h43, 0);
      wait_dump("end_nbytes", db, 5000);
      i_program_end = 1'b0;
      chk("end_halt_low", 64'(halt_low_cnt - hb), 64'd0);
      chk("end_errs", 64'(dump_errs(db)), 64'd0);

      // Slow receiver: 100-cycle acknowledge
      tx_delay = 100;
      db = dump_q.size(); ob = overlap_err; sb = stable_err;
      send_byte(8'h53, 0);
      wait_dump("hs_nbytes", db, 40000);
      chk("hs_overlap", 64'(overlap_err - ob), 64'd0);
      chk("hs_stable",  64'(stable_err - sb), 64'd0);
      chk("hs_errs",    64'(dump_errs(db)), 64'd0);

      // Reset mid-dump: nothing resumes
      tx_delay = 2;
      db = dump_q.size();
      send_byte(8'h53, 0);
      for (int c = 0; c < 5000 && dump_q.size() < db + 60; c++) @(negedge i_clk);
      pulse_reset();
      @(negedge i_clk);
      db = dump_q.size();
      repeat (50) @(negedge i_clk);
      chk("rstdp_ntx",    64'(dump_q.size() - db), 64'd0);
      chk("rstdp_halt",   64'(o_halt), 64'd1);
      chk("rstdp_txd",    64'(o_tx_data), 64'd0);
      chk("rstdp_regrd",  64'(o_reg_read), 64'd0);
      chk("rstdp_rdaddr", 64'(o_address_to_read), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/debug_unit.md
DEBUG_UNIT -- requirements
Module: debug_unit

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 256, meaning instruction-memory depth in 32-bit words.
REQ-002 SHALL have parameter DUMP_MEM_WORDS, default 32, meaning data-memory words dumped from address 0.
REQ-003 SHALL have ports, clock and reset first:
- i_clk  in  1  single clock; all logic on rising edge.
- i_reset  in  1  reset, synchronous, active-high.
- i_rx_data  in  8  received UART byte.
- i_rx_done  in  1  one-cycle pulse: i_rx_data valid.
- i_tx_done  in  1  one-cycle pulse: previous byte sent.
- o_tx_data  out  8  byte to transmit.
- o_tx_start  out  1  one-cycle transmit request.
- o_halt  out  1  freezes pipeline when high.
- o_write_instruction_flag  out  1  one-cycle instruction-memory write strobe.
- o_instruction_to_write  out  32  word to write.
- o_address_to_write_inst  out  32  byte address of word.
- i_IF_ID_latch  in  64.
- i_ID_EX_latch  in  139.
- i_EX_MEM_latch  in  76.
- i_MEM_WB_latch  in  71.
- o_reg_read  out  5  register index to read.
- i_reg_content  in  32  register value, valid one cycle after o_reg_read changes.
- o_address_to_read  out  32  data-memory byte address to read.
- i_mem_addr_content  in  32  memory word, valid one cycle after o_address_to_read changes.
- i_program_end  in  1  pipeline has retired the HALT instruction.

Function
REQ-004 SHALL implement states IDLE, LOAD_COUNT, LOAD_BYTES, LOAD_WRITE, RUN, STEP, DUMP, TX_WAIT.
REQ-005 SHALL, in IDLE, decode a received byte: 0x4C 'L' -> LOAD_COUNT; 0x43 'C' -> RUN; 0x53 'S' -> STEP; any other byte ignored, remaining in IDLE.
REQ-006 SHALL, in LOAD_COUNT, take the next byte as word count N. N=0 returns to IDLE with no write. N>IMEM_WORDS is clamped to IMEM_WORDS.
REQ-007 SHALL assemble each word from 4 bytes, MSB first, then in LOAD_WRITE pulse o_write_instruction_flag for exactly 1 cycle with address 4*k, k=0..N-1.
REQ-008 SHALL return to IDLE after the N-th write.
REQ-009 SHALL hold o_halt high in every state except RUN and the single STEP cycle.
REQ-010 SHALL, in RUN, hold o_halt low until the cycle i_program_end is sampled high, then raise o_halt on the next edge and enter DUMP.
REQ-011 SHALL, in STEP, drive o_halt low for exactly one cycle, then enter DUMP.
REQ-012 SHALL, if i_program_end is high when 'C' or 'S' is received, skip execution and enter DUMP directly.
REQ-013 SHALL snapshot all four latches on DUMP entry and serialize the snapshot, not live values.
REQ-014 SHALL send the dump as the following 301 bytes, each MSB-first, with each latch zero-extended at the top to whole bytes:
- IF_ID: 8 bytes.
- ID_EX: 18 bytes.
- EX_MEM: 10 bytes.
- MEM_WB: 9 bytes.
- Registers 0..31: 4 bytes each.
- Memory words at addresses 0, 4, ..., 4*(DUMP_MEM_WORDS-1): 4 bytes each.
REQ-015 SHALL, for each register or memory word, set the address, wait one cycle, capture the value, then send its 4 bytes.
REQ-016 SHALL send each byte by pulsing o_tx_start for 1 cycle with o_tx_data stable, then wait in TX_WAIT for i_tx_done. o_tx_data SHALL be held until i_tx_done.
REQ-017 SHALL return to IDLE after the last dump byte.
REQ-018 SHALL ignore i_rx_done in RUN, STEP, DUMP and TX_WAIT.
REQ-019 SHALL keep the byte counter, word counter and address counters width-safe, with no wrap inside one transfer.

Reset
REQ-020 SHALL, when i_reset is sampled high, enter IDLE from any state, including mid-load and mid-dump.
REQ-021 SHALL drive these values from reset:
- o_halt = 1.
- o_write_instruction_flag = 0.
- o_tx_start = 0.
- o_tx_data = 0.
- o_instruction_to_write = 0.
- o_address_to_write_inst = 0.
- o_reg_read = 0.
- o_address_to_read = 0.
- All counters and the snapshot = 0.
REQ-022 SHALL abandon any partial word or partial dump on reset; nothing resumes after reset.

Structure
REQ-023 SHALL place command codes, state encoding, latch widths and dump byte counts in a shared package debug_pkg.
REQ-024 SHALL use one sub-module, dump_serializer, which converts a word into an MSB-first byte stream with the tx handshake; the FSM stays in debug_unit.

Verification
REQ-025 Load test: send 'L', 0x02, 0x20,0x01,0x00,0x05, 0x00,0x00,0x00,0x00 -> two write pulses: addr 0 with 0x20010005, then addr 4 with 0x00000000; o_halt stays 1; FSM returns to IDLE.
REQ-026 Step test: send 'S' -> o_halt low exactly 1 cycle, then 301 o_tx_start pulses; byte 0 equals i_IF_ID_latch[63:56] as sampled at DUMP entry.
REQ-027 Run test: send 'C', assert i_program_end 20 cycles later -> o_halt low for 20 cycles, high 1 cycle after i_program_end, then full 301-byte dump.
REQ-028 Handshake test: i_tx_done delayed 100 cycles per byte -> no second o_tx_start before i_tx_done; o_tx_data unchanged while waiting.
REQ-029 Reset test: assert i_reset after the 3rd byte of a load word -> no write pulse; o_halt = 1; next 'L' starts cleanly at address 0.
REQ-030 Unknown-command test: send 0x7A, then 'L', 0x00 -> no writes, no tx, remains in IDLE.
